// File: rtl/cfg_arb_pkg.sv
// Shared types and constants for the config bank arbiter.
//   arb_state_e : access FSM states (idle, access in progress, completion)
//   REQ_SPI     : requester index of the SPI side
//   REQ_SEQ     : requester index of the on-chip sequencer
package cfg_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } arb_state_e;

  localparam int unsigned REQ_SPI = 0;
  localparam int unsigned REQ_SEQ = 1;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way combinational round-robin decision.
//   req         : request bits, one per requester
//   ptr         : requester favoured when both request
//   grant_idx   : index of the winning requester
//   grant_valid : high when any requester is asking
module rr_arbiter_2
  import cfg_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       grant_idx,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    // A lone requester wins outright; on contention the pointer decides.
    grant_idx   = (req == 2'b11) ? ptr : req[REQ_SEQ];
  end

endmodule

// File: rtl/cfg_bank_arbiter.sv
// Arbitrated access to a bank of writable config registers and read-only
// status registers, shared by an SPI-side requester and an on-chip sequencer.
// Each access walks idle -> access -> done; one access is in flight at a time.
//   clk, rstb    : clock, asynchronous active-low reset
//   ena          : allows new grants out of idle
//   req, we      : per-requester request and write/read select
//   addr, wdata  : per-requester address and write data (packed, requester n in slice n)
//   ack, err     : per-requester one-cycle completion / error pulses
//   rdata        : last read value, valid while ack is high
//   config_regs  : packed config register contents
//   status_regs  : packed status register inputs
module cfg_bank_arbiter
  import cfg_arb_pkg::*;
#(
  parameter int unsigned NUM_CFG    = 8,
  parameter int unsigned NUM_STATUS = 8,  // must equal NUM_CFG
  parameter int unsigned REG_WIDTH  = 8,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_CFG + NUM_STATUS)
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            ena,
  input  logic [1:0]                      req,
  input  logic [1:0]                      we,
  input  logic [2*ADDR_WIDTH-1:0]         addr,
  input  logic [2*REG_WIDTH-1:0]          wdata,
  output logic [1:0]                      ack,
  output logic [REG_WIDTH-1:0]            rdata,
  output logic [1:0]                      err,
  output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
  input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs
);

  localparam int unsigned IDX_W = ADDR_WIDTH - 1;

  arb_state_e             state_q;
  logic                   ptr_q;
  logic                   win_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [REG_WIDTH-1:0]   wdata_q;
  logic [REG_WIDTH-1:0]   rdata_q;
  logic [1:0]             ack_q;
  logic [1:0]             err_q;
  logic [REG_WIDTH-1:0]   cfg_q [NUM_CFG];

  logic                   grant_idx;
  logic                   grant_valid;
  logic                   we_sel;
  logic [ADDR_WIDTH-1:0]  addr_sel;
  logic [REG_WIDTH-1:0]   wdata_sel;
  logic                   is_status;
  logic [IDX_W-1:0]       idx;
  logic [REG_WIDTH-1:0]   rd_val;

  rr_arbiter_2 u_rr (
    .req         (req),
    .ptr         (ptr_q),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Fields of the requester that wins this cycle.
  always_comb begin
    we_sel    = grant_idx ? we[1] : we[0];
    addr_sel  = grant_idx ? addr[ADDR_WIDTH +: ADDR_WIDTH] : addr[0 +: ADDR_WIDTH];
    wdata_sel = grant_idx ? wdata[REG_WIDTH +: REG_WIDTH] : wdata[0 +: REG_WIDTH];
  end

  // Address MSB selects the status half; remaining bits index the register.
  assign is_status = addr_q[ADDR_WIDTH-1];
  assign idx       = addr_q[IDX_W-1:0];

  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      if (32'(idx) == i) begin
        rd_val = is_status ? status_regs[i*REG_WIDTH +: REG_WIDTH] : cfg_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= StIdle;
      ptr_q   <= 1'(REQ_SPI);
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      for (int unsigned i = 0; i < NUM_CFG; i++) begin
        cfg_q[i] <= '0;
      end
    end else begin
      ack_q <= '0;
      err_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (ena && grant_valid) begin
            win_q   <= grant_idx;
            we_q    <= we_sel;
            addr_q  <= addr_sel;
            wdata_q <= wdata_sel;
            // The requester just served loses the next tie.
            ptr_q   <= ~grant_idx;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          // Completion flags are registered here so they show during done.
          ack_q[win_q] <= 1'b1;
          if (we_q) begin
            if (is_status) begin
              err_q[win_q] <= 1'b1;
            end else begin
              for (int unsigned i = 0; i < NUM_CFG; i++) begin
                if (32'(idx) == i) begin
                  cfg_q[i] <= wdata_q;
                end
              end
            end
          end else begin
            rdata_q <= rd_val;
          end
          state_q <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    config_regs = '0;
    for (int unsigned i = 0; i < NUM_CFG; i++) begin
      config_regs[i*REG_WIDTH +: REG_WIDTH] = cfg_q[i];
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_cfg_bank_arbiter.sv
// Bench for cfg_bank_arbiter: directed cases followed by randomized traffic,
// checked against a transaction-level register-bank model.
module tb_cfg_bank_arbiter;

  localparam int unsigned NC = 8;
  localparam int unsigned NS = 8;
  localparam int unsigned RW = 8;
  localparam int unsigned AW = 4;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              ena = 1'b0;
  logic [1:0]        req = '0;
  logic [1:0]        we = '0;
  logic [2*AW-1:0]   addr = '0;
  logic [2*RW-1:0]   wdata = '0;
  logic [1:0]        ack;
  logic [RW-1:0]     rdata;
  logic [1:0]        err;
  logic [NC*RW-1:0]  config_regs;
  logic [NS*RW-1:0]  status_regs = '0;

  always #5 clk = ~clk;

  cfg_bank_arbiter #(
    .NUM_CFG    (NC),
    .NUM_STATUS (NS),
    .REG_WIDTH  (RW)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .ena         (ena),
    .req         (req),
    .we          (we),
    .addr        (addr),
    .wdata       (wdata),
    .ack         (ack),
    .rdata       (rdata),
    .err         (err),
    .config_regs (config_regs),
    .status_regs (status_regs)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: register contents, last read value, last served.
  logic [RW-1:0] m_cfg [NC];
  logic [RW-1:0] m_rd;
  int            m_last;

  // Operations as issued (the DUT inputs may be scrambled afterwards).
  logic          op_we [2];
  logic [AW-1:0] op_a  [2];
  logic [RW-1:0] op_d  [2];

  // Observations per requester from the last run.
  int            ack_cyc [2];
  logic [RW-1:0] ack_rd  [2];
  logic          ack_err [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NC); i++) m_cfg[i] = '0;
    m_rd   = '0;
    m_last = 1;  // so requester 0 is favoured first
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    req  = '0;
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    model_reset();
  endtask

  task automatic set_op(input int r, input logic w, input logic [AW-1:0] a,
                        input logic [RW-1:0] d);
    we[r]             = w;
    addr[r*AW +: AW]  = a;
    wdata[r*RW +: RW] = d;
    op_we[r] = w;
    op_a[r]  = a;
    op_d[r]  = d;
  endtask

  function automatic logic [NC*RW-1:0] m_pack();
    logic [NC*RW-1:0] p;
    for (int i = 0; i < int'(NC); i++) p[i*RW +: RW] = m_cfg[i];
    return p;
  endfunction

  // Apply one served access to the model.
  task automatic model_txn(input int r, output logic [RW-1:0] rd, output logic e);
    int a;
    a = int'(op_a[r]);
    e = 1'b0;
    if (a < int'(NC)) begin
      if (op_we[r]) m_cfg[a] = op_d[r];
      else          m_rd = m_cfg[a];
    end else begin
      if (op_we[r]) e = 1'b1;
      else          m_rd = status_regs[(a - int'(NC))*RW +: RW];
    end
    rd     = m_rd;
    m_last = r;
  endtask

  // Raise the requests in mask, collect acks with a cycle budget, drop each
  // request once its ack is seen.
  task automatic run(input logic [1:0] mask, input bit scramble);
    logic [1:0] pend;
    pend       = mask;
    ack_cyc[0] = -1;
    ack_cyc[1] = -1;
    req        = mask;
    for (int c = 1; c <= 12 && pend != 2'b00; c++) begin
      step();
      chk("err_without_ack", 64'(err & ~ack), 64'd0);
      for (int r = 0; r < 2; r++) begin
        if (ack[r] && pend[r]) begin
          ack_cyc[r] = c;
          ack_rd[r]  = rdata;
          ack_err[r] = err[r];
          pend[r]    = 1'b0;
          req[r]     = 1'b0;
        end
      end
      if (scramble && c == 1) begin
        addr  = 8'($urandom);
        wdata = 16'($urandom);
        we    = ~we;
      end
    end
    step();
    chk("ack_one_cycle", 64'(ack), 64'd0);
  endtask

  task automatic verify(input logic [1:0] mask);
    logic [RW-1:0] rd;
    logic          e;
    int            first;
    if (mask == 2'b11) begin
      first = (m_last == 0) ? 1 : 0;
      model_txn(first, rd, e);
      chk("dual_first_lat", 64'(ack_cyc[first]), 64'd2);
      chk("dual_first_rdata", 64'(ack_rd[first]), 64'(rd));
      chk("dual_first_err", 64'(ack_err[first]), 64'(e));
      model_txn(1 - first, rd, e);
      chk("dual_second_lat", 64'(ack_cyc[1-first]), 64'd5);
      chk("dual_second_rdata", 64'(ack_rd[1-first]), 64'(rd));
      chk("dual_second_err", 64'(ack_err[1-first]), 64'(e));
    end else begin
      first = mask[1] ? 1 : 0;
      model_txn(first, rd, e);
      chk("lat", 64'(ack_cyc[first]), 64'd2);
      chk("rdata", 64'(ack_rd[first]), 64'(rd));
      chk("err", 64'(ack_err[first]), 64'(e));
    end
    chk("config_regs", 64'(config_regs), 64'(m_pack()));
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_ack", 64'(ack), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_config", 64'(config_regs), 64'd0);
    ena = 1'b1;

    // Requester 0 writes 0xA5 to config 3.
    set_op(0, 1'b1, 4'd3, 8'hA5);
    run(2'b01, 1'b0);
    verify(2'b01);
    chk("cfg3_a5", 64'(config_regs[31:24]), 64'hA5);

    // Requester 1 reads status 2 (address 10).
    status_regs = 64'($urandom) << 32 | 64'($urandom);
    status_regs[23:16] = 8'h3C;
    set_op(1, 1'b0, 4'd10, 8'h00);
    run(2'b10, 1'b0);
    verify(2'b10);
    chk("status_read_3c", 64'(ack_rd[1]), 64'h3C);

    // Write to the status half is rejected with an error.
    set_op(0, 1'b1, 4'd9, 8'hFF);
    run(2'b01, 1'b0);
    verify(2'b01);
    chk("status_write_err", 64'(ack_err[0]), 64'd1);

    // Both write the same register on the same cycle straight out of reset.
    do_reset();
    ena = 1'b1;
    set_op(0, 1'b1, 4'd5, 8'h12);
    set_op(1, 1'b1, 4'd5, 8'h34);
    run(2'b11, 1'b0);
    chk("contend_ack0_cycle", 64'(ack_cyc[0]), 64'd2);
    chk("contend_ack1_cycle", 64'(ack_cyc[1]), 64'd5);
    verify(2'b11);
    chk("contend_last_wins", 64'(config_regs[47:40]), 64'h34);

    // Disabled: a pending request is held off until ena rises.
    ena = 1'b0;
    set_op(0, 1'b0, 4'd3, 8'h00);
    req = 2'b01;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("ena_low_no_ack", 64'(ack), 64'd0);
    end
    ena = 1'b1;
    run(2'b01, 1'b0);
    verify(2'b01);

    // Reset while the write is in the access state aborts it.
    set_op(0, 1'b1, 4'd0, 8'h11);
    req = 2'b01;
    step();
    rstb = 1'b0;
    #2;
    chk("abort_ack_in_reset", 64'(ack), 64'd0);
    req  = '0;
    rstb = 1'b1;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("abort_no_ack", 64'(ack), 64'd0);
    end
    chk("abort_cfg0", 64'(config_regs[7:0]), 64'd0);
    chk("abort_config", 64'(config_regs), 64'(m_pack()));

    // Randomized traffic; single accesses have their inputs scrambled after
    // the latch to confirm the in-flight access is isolated.
    for (int n = 0; n < 80; n++) begin
      logic [1:0] mask;
      status_regs = 64'($urandom) << 32 | 64'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 2'b11 : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      for (int r = 0; r < 2; r++) begin
        set_op(r, 1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom));
      end
      run(mask, mask != 2'b11);
      verify(mask);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_bank_arbiter.md
CFG_BANK_ARBITER -- requirements
Module: cfg_bank_arbiter

Interface
REQ-001 SHALL take parameter NUM_CFG, default 8, number of writable config registers.
REQ-002 SHALL take parameter NUM_STATUS, default 8, number of read-only status registers; must equal NUM_CFG.
REQ-003 SHALL take parameter REG_WIDTH, default 8, register width in bits.
REQ-004 SHALL derive localparam ADDR_WIDTH = $clog2(NUM_CFG+NUM_STATUS).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port rstb  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port ena  input  1  design enable; gates new grants.
REQ-008 SHALL have port req  input  2  access request per requester (bit 0 = SPI side, bit 1 = on-chip sequencer).
REQ-009 SHALL have port we  input  2  per-requester write (1) / read (0).
REQ-010 SHALL have port addr  input  2*ADDR_WIDTH  per-requester address, requester n at [n*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 SHALL have port wdata  input  2*REG_WIDTH  per-requester write data, same slicing.
REQ-012 SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-013 SHALL have port rdata  output  REG_WIDTH  read data, valid while any ack bit is high.
REQ-014 SHALL have port err  output  2  per-requester error pulse, coincident with ack.
REQ-015 SHALL have port config_regs  output  NUM_CFG*REG_WIDTH  register i at [i*REG_WIDTH +: REG_WIDTH].
REQ-016 SHALL have port status_regs  input  NUM_STATUS*REG_WIDTH  status i at [i*REG_WIDTH +: REG_WIDTH].

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE; one access in flight at a time.
REQ-018 IDLE: if ena=1 and any eligible req bit set, SHALL latch winner index, its we/addr/wdata, go ACCESS; else stay IDLE.
REQ-019 Arbitration SHALL be round-robin: single requester wins alone; both requesting -> non-last-served wins; priority pointer resets to requester 0 favoured.
REQ-020 ACCESS: address MSB=0 and write -> config register addr[ADDR_WIDTH-2:0] SHALL update at end of cycle; read -> rdata SHALL load that config register.
REQ-021 ACCESS: address MSB=1 and read -> rdata SHALL load status_regs entry addr[ADDR_WIDTH-2:0]; write -> no register change, err of winner SHALL be set.
REQ-022 DONE: ack[winner] SHALL be 1 for exactly this cycle, err as per REQ-021, rdata held; next state IDLE.
REQ-023 Requester SHALL drop req on the clock edge at which it samples ack=1; the winner's req SHALL be ignored during DONE.
REQ-024 Latency: req sampled in IDLE -> ack 2 cycles later; sustained throughput one access per 3 cycles.
REQ-025 ena=0 SHALL block transition out of IDLE only; an access in ACCESS/DONE SHALL complete.
REQ-026 rdata SHALL retain last read value until next read; writes SHALL not change rdata.
REQ-027 Simultaneous write from both requesters to same register SHALL be serialised; final value is from the later-served requester.
REQ-028 Request changes (addr/wdata) after latch SHALL NOT affect the in-flight access.

Reset
REQ-029 On rstb low, asynchronously: state IDLE, all config registers 0, ack 0, err 0, rdata 0, pointer favouring requester 0.
REQ-030 Reset mid-access SHALL abort it with no ack and no register update after release.

Structure
REQ-031 Package cfg_arb_pkg SHALL hold the FSM state enum and requester index constants (REQ_SPI=0, REQ_SEQ=1).
REQ-032 Round-robin decision SHALL be a sub-module rr_arbiter_2 (req[1:0], pointer in, grant index + valid out), combinational.

Verification
REQ-033 Reset release, requester 0 writes 0xA5 to addr 3 -> ack[0] 2 cycles after req, config_regs[31:24]=0xA5, err=0.
REQ-034 Both requesters request on same cycle from reset -> requester 0 acked first, requester 1 acked 3 cycles later.
REQ-035 Requester 1 reads addr 10 with status_regs[23:16]=0x3C -> rdata=0x3C with ack[1], err[1]=0.
REQ-036 Requester 0 writes 0xFF to addr 9 -> ack[0] and err[0] pulse together, config_regs unchanged.
REQ-037 ena=0 with req[0]=1 for 5 cycles -> no ack; ena raised -> ack[0] 2 cycles later.
REQ-038 rstb low during ACCESS of write 0x11 to addr 0 -> no ack, config_regs[7:0]=0 after release.
